// File: rtl/vedic_mul_8x8.sv
// vedic_mul_8x8: unsigned 8x8 -> 16-bit multiplier.
// The core uses the Urdhva-Tiryagbhyam scheme. It is built in three levels:
// 2x2 cells, then 4x4 cells, then the 8x8 cell. Each level combines four
// smaller products with adder trees. A single output register gives a fixed
// latency of one cycle.
module vedic_mul_8x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] prod
);

    // 2x2 cell: bit 0 is a0b0.
    // Two half-adders fold the cross terms, then a1b1 with the carry.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
        logic       t_lo;
        logic       t_x0;
        logic       t_x1;
        logic       t_hi;
        logic       s1;
        logic       c1;
        logic       s2;
        logic       c2;
        t_lo = x[0] & y[0];
        t_x0 = x[1] & y[0];
        t_x1 = x[0] & y[1];
        t_hi = x[1] & y[1];
        s1   = t_x0 ^ t_x1;
        c1   = t_x0 & t_x1;
        s2   = t_hi ^ c1;
        c2   = t_hi & c1;
        return {c2, s2, s1, t_lo};
    endfunction

    // 4x4 cell: LL + (LH+HL)<<2 + HH<<4.
    // The middle sum keeps its carry, so the 8-bit result is exact.
    function automatic logic [7:0] vedic_4x4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] ll;
        logic [3:0] lh;
        logic [3:0] hl;
        logic [3:0] hh;
        logic [4:0] mid;
        ll  = vedic_2x2(x[1:0], y[1:0]);
        lh  = vedic_2x2(x[1:0], y[3:2]);
        hl  = vedic_2x2(x[3:2], y[1:0]);
        hh  = vedic_2x2(x[3:2], y[3:2]);
        mid = {1'b0, lh} + {1'b0, hl};
        return {4'b0, ll} + {1'b0, mid, 2'b0} + {hh, 4'b0};
    endfunction

    // 8x8 cell: LL + (LH+HL)<<4 + HH<<8.
    // The result is an exact 16-bit product with no truncation.
    function automatic logic [15:0] vedic_8x8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] ll;
        logic [7:0] lh;
        logic [7:0] hl;
        logic [7:0] hh;
        logic [8:0] mid;
        ll  = vedic_4x4(x[3:0], y[3:0]);
        lh  = vedic_4x4(x[3:0], y[7:4]);
        hl  = vedic_4x4(x[7:4], y[3:0]);
        hh  = vedic_4x4(x[7:4], y[7:4]);
        mid = {1'b0, lh} + {1'b0, hl};
        return {8'b0, ll} + {3'b0, mid, 4'b0} + {hh, 8'b0};
    endfunction

    logic [15:0] core_p0;

    // Stage 0: purely combinational product of the current operands.
    always_comb begin
        core_p0 = vedic_8x8(a, b);
    end

    // Stage 1: output register.
    // An asynchronous clear discards any in-flight product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod <= 16'h0000;
        else
            prod <= core_p0;
    end

endmodule

// File: tb/tb_vedic_mul_8x8.sv
// tb_vedic_mul_8x8: directed and random checks of the registered Vedic multiplier.
module tb_vedic_mul_8x8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;

    int n_checks;
    int n_errors;

    vedic_mul_8x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .prod  (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%04h), expected %0d (0x%04h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive one pair, take one edge, and compare one step after the edge.
    task automatic apply(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        check(tag, prod, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        a        = 8'hFF;
        b        = 8'hFF;

        // Reset held with max operands and a running clock.
        #1;
        check("reset_async", prod, 16'h0000);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", prod, 16'h0000);
        end

        // Release between edges; the first edge loads 255*255.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", prod, 16'h0000);
        @(posedge clk);
        #1;
        check("release_first", prod, 16'hFE01);

        // Latency: the new product appears after the next edge, not before.
        a = 8'd3;
        b = 8'd5;
        #3;
        check("latency_before", prod, 16'hFE01);
        @(posedge clk);
        #1;
        check("latency_3x5", prod, 16'd15);
        apply("latency_10x20", 8'd10, 8'd20, 16'd200);

        // Corner cases.
        apply("zero_a", 8'd0, 8'd200, 16'd0);
        apply("zero_b", 8'd77, 8'd0, 16'd0);
        apply("one_x_255", 8'd1, 8'd255, 16'd255);
        apply("max_x_max", 8'd255, 8'd255, 16'd65025);
        apply("128x2", 8'd128, 8'd2, 16'd256);
        apply("16x16", 8'd16, 8'd16, 16'd256);

        // Carries that cross the half boundaries.
        apply("15x15", 8'd15, 8'd15, 16'd225);
        apply("240x15", 8'd240, 8'd15, 16'd3600);
        apply("129x127", 8'd129, 8'd127, 16'd16383);
        apply("3x3", 8'd3, 8'd3, 16'd9);
        apply("2x2cell_carry", 8'h33, 8'h33, 16'd2601);

        // Random pairs, one per cycle, each compared after its edge.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0]  ra;
            logic [7:0]  rb;
            logic [15:0] exp;
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            exp = 16'(ra) * 16'(rb);
            apply("random", ra, rb, exp);
        end

        // Asynchronous reset mid-run, between edges.
        apply("pre_reset_170x85", 8'd170, 8'd85, 16'd14450);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mid_run", prod, 16'h0000);
        @(posedge clk);
        #1;
        check("async_hold", prod, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply("after_reset", 8'd12, 8'd12, 16'd144);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
